// File: rtl/relu_seq_ctrl_if.sv
// Bus between the ReLU sequencer and its surroundings: layer-controller
// config/start, source buffer read port, relu_pe hookup, destination write
// port and run status.
interface relu_seq_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
);
  logic              start;
  logic              cfg_relu;
  logic [LEN_W-1:0]  cfg_len;
  logic [ADDR_W-1:0] cfg_src_base;
  logic [ADDR_W-1:0] cfg_dst_base;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] buf_rdata;
  logic              relu_en;
  logic [DATA_W-1:0] relu_out;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  neg_count;

  // Environment side: controller, buffers and the PE.
  modport master (
    output start, cfg_relu, cfg_len, cfg_src_base, cfg_dst_base, buf_rdata, relu_out,
    input  rd_en, rd_addr, relu_en, wr_en, wr_addr, wr_data, busy, done, neg_count
  );

  // Sequencer side.
  modport slave (
    input  start, cfg_relu, cfg_len, cfg_src_base, cfg_dst_base, buf_rdata, relu_out,
    output rd_en, rd_addr, relu_en, wr_en, wr_addr, wr_data, busy, done, neg_count
  );
endinterface

// File: rtl/relu_seq_ctrl.sv
// ReLU stage sequencer: reads a block from the output buffer, passes it
// through relu_pe (or bypasses it) and writes the result to the destination
// buffer. A valid tag and destination address travel alongside each read so
// the write lines up with the PE output regardless of RD_LAT.
module relu_seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9,
  parameter int RD_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  relu_seq_ctrl_if.slave  io
);
  // Tag stage k is valid k cycles after the read; stage RD_LAT lines up with
  // buf_rdata and stage STAGES with relu_out.
  localparam int STAGES = RD_LAT + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic              relu;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
  } cfg_t;

  state_t                        state_q, state_d;
  cfg_t                          cfg_q, cfg_d;
  logic [LEN_W-1:0]              rd_idx_q, rd_idx_d;
  logic [STAGES:1]               vld_q, vld_d;
  logic [STAGES:1][ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]             raw_q, raw_d;
  logic                          wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]             wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]             wr_data_q, wr_data_d;
  logic [LEN_W-1:0]              neg_q, neg_d;
  logic                          accept;
  logic                          rd_fire;
  logic                          in_flight;
  logic                          active;

  // Anything still between the read port and the write register.
  assign in_flight = |vld_q;
  assign active    = (state_q == RUN) || (state_q == DRAIN);

  // Next-state logic: config latch, read index and state transitions.
  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    rd_idx_d = rd_idx_q;
    accept   = 1'b0;
    rd_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (io.start) begin
          accept         = 1'b1;
          cfg_d.relu     = io.cfg_relu;
          cfg_d.len      = io.cfg_len;
          cfg_d.src_base = io.cfg_src_base;
          cfg_d.dst_base = io.cfg_dst_base;
          rd_idx_d       = '0;
          state_d        = (io.cfg_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        rd_fire  = 1'b1;
        rd_idx_d = rd_idx_q + LEN_W'(1);
        if (rd_idx_q == cfg_q.len - LEN_W'(1)) state_d = DRAIN;
      end
      DRAIN:   if (!in_flight) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cfg_q    <= '0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Tag/address pipeline, raw-data delay, write register and negative count.
  // Data regs only load on valid stages so junk on buf_rdata never leaks in.
  always_comb begin
    vld_d      = '0;
    waddr_d    = waddr_q;
    vld_d[1]   = rd_fire;
    waddr_d[1] = cfg_q.dst_base + ADDR_W'(rd_idx_q);
    for (int k = 2; k <= STAGES; k++) begin
      vld_d[k]   = vld_q[k-1];
      waddr_d[k] = waddr_q[k-1];
    end
    raw_d     = vld_q[RD_LAT] ? io.buf_rdata : raw_q;
    neg_d     = neg_q;
    if (accept)
      neg_d = '0;
    else if (vld_q[RD_LAT] && io.buf_rdata[DATA_W-1])
      neg_d = neg_q + LEN_W'(1);
    wr_en_d   = vld_q[STAGES];
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (vld_q[STAGES]) begin
      wr_addr_d = waddr_q[STAGES];
      wr_data_d = cfg_q.relu ? io.relu_out : raw_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      waddr_q   <= '0;
      raw_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      neg_q     <= '0;
    end else begin
      vld_q     <= vld_d;
      waddr_q   <= waddr_d;
      raw_q     <= raw_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      neg_q     <= neg_d;
    end
  end

  assign io.rd_en     = rd_fire;
  assign io.rd_addr   = rd_fire ? cfg_q.src_base + ADDR_W'(rd_idx_q) : '0;
  assign io.relu_en   = active && cfg_q.relu;
  assign io.busy      = active;
  assign io.done      = (state_q == DONE);
  assign io.wr_en     = wr_en_q;
  assign io.wr_addr   = wr_addr_q;
  assign io.wr_data   = wr_data_q;
  assign io.neg_count = neg_q;
endmodule
